// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N:1 arbitrated mux (round-robin or fixed priority) with registered valid/ready output
module rr_arb_mux #(
  parameter int N = 4,
  parameter int WIDTH = 8,
  parameter int MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N-1:0]             in_valid,
  input  logic [N*WIDTH-1:0]       in_data,
  output logic [N-1:0]             in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(N)-1:0]     out_sel
);
  localparam int SEL_W = $clog2(N);
  logic [SEL_W-1:0] ptr, g;
  logic any, load;
  // Scan from lowest priority to highest so the last hit is the winner
  always_comb begin
    g = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--)
      if (in_valid[(MODE == 1) ? k : (int'(ptr) + k) % N]) begin
        g = SEL_W'((MODE == 1) ? k : (int'(ptr) + k) % N);
        any = 1'b1;
      end
  end
  assign load = any & (~out_valid | out_ready) & ~rst;
  assign in_ready = load ? (N'(1) << g) : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_sel <= '0;
      ptr <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data <= in_data[g*WIDTH +: WIDTH];
      out_sel <= g;
      ptr <= (g == SEL_W'(N - 1)) ? '0 : g + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule
